// File: rtl/aoi_check_pkg.sv
// Shared types and helpers for the AOI sweep checker.
//   state_t      : checker FSM states
//   LFSR_TAPS    : Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   aoi_expect   : reference AOI function (a&b)|(c&d)
//   lfsr_step    : one Galois LFSR advance
//   abcd_to_dcba : reorders an {a,b,c,d} nibble into the {d,c,b,a} stimulus register layout
package aoi_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        RANDOM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic aoi_expect(input logic a, input logic b,
                                        input logic c, input logic d);
        return (a & b) | (c & d);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

    function automatic logic [3:0] abcd_to_dcba(input logic [3:0] n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used for the pseudo-random stimulus phase.
//   clk     : clock
//   reset   : synchronous active-high reset, loads seed
//   load    : reload seed (start of a run)
//   seed    : value loaded on reset/load; must be nonzero
//   advance : step the LFSR once
//   q       : current LFSR state
module lfsr16
    import aoi_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (advance) begin
            q_d = lfsr_step(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/aoi_sweep_checker.sv
// Driver/checker for a 4-input AND-OR-INVERT block: drives a..d, samples
// out/out_n, runs an exhaustive sweep then a pseudo-random phase and keeps
// mismatch statistics.
//   clk, reset     : clock, synchronous active-high reset
//   start          : one-cycle run request, honoured in IDLE or DONE
//   a, b, c, d     : registered stimulus to the AOI block
//   out, out_n     : AOI block response
//   busy, done     : run in progress / run finished
//   pass           : valid while done, 1 when no mismatches
//   err_count      : saturating mismatch count
//   first_err_idx  : sample index of the first mismatch
//   sample_count   : samples taken in the current run
//
// state  | meaning
// IDLE   | after reset, waiting for start
// SWEEP  | {d,c,b,a} counts up one per sample
// RANDOM | {a,b,c,d} taken from the LFSR after each advance
// DONE   | results held until start or reset
module aoi_sweep_checker
    import aoi_check_pkg::*;
#(
    parameter int unsigned SWEEP_LEN = 20,
    parameter int unsigned RAND_LEN  = 100,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             out,
    input  logic             out_n,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] sample_count
);

    // Phase timer is a down-counter; a phase ends on the sample taken at zero.
    localparam logic [15:0] SWEEP_LAST = (SWEEP_LEN == 0) ? 16'd0 : 16'(SWEEP_LEN - 1);
    localparam logic [15:0] RAND_LAST  = (RAND_LEN == 0)  ? 16'd0 : 16'(RAND_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [3:0]        stim_q, stim_d;     // {d,c,b,a}
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  first_q, first_d;
    logic [CNT_W-1:0]  samp_q, samp_d;
    logic [15:0]       phase_q, phase_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_nxt;
    logic              lfsr_load;
    logic              lfsr_adv;

    logic              start_ok;
    logic              sampling;
    logic              phase_end;
    logic              exp_v;
    logic              mismatch;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (LFSR_SEED),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

    assign lfsr_nxt  = lfsr_step(lfsr_q);
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign sampling  = (state_q == SWEEP) || (state_q == RANDOM);
    assign phase_end = sampling && (phase_q == 16'd0);
    assign exp_v     = aoi_expect(stim_q[0], stim_q[1], stim_q[2], stim_q[3]);
    // Case inequality so an X/Z response is scored as a mismatch in simulation.
    assign mismatch  = (out !== exp_v) || (out_n !== ~exp_v);

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stim_q  <= 4'h0;
            err_q   <= '0;
            first_q <= '0;
            samp_q  <= '0;
            phase_q <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            err_q   <= err_d;
            first_q <= first_d;
            samp_q  <= samp_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next state; empty phases are skipped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (SWEEP_LEN != 0)     state_d = SWEEP;
                    else if (RAND_LEN != 0) state_d = RANDOM;
                    else                    state_d = DONE;
                end
            end
            SWEEP: begin
                if (phase_end) state_d = (RAND_LEN != 0) ? RANDOM : DONE;
            end
            RANDOM: begin
                if (phase_end) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath
    always_comb begin
        stim_d    = stim_q;
        err_d     = err_q;
        first_d   = first_q;
        samp_d    = samp_q;
        phase_d   = phase_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        if (start_ok) begin
            err_d     = '0;
            first_d   = '0;
            samp_d    = '0;
            lfsr_load = 1'b1;
            if (SWEEP_LEN != 0) begin
                stim_d  = 4'h0;
                phase_d = SWEEP_LAST;
            end else begin
                stim_d  = abcd_to_dcba(LFSR_SEED[3:0]);
                phase_d = RAND_LAST;
            end
        end else if (sampling) begin
            samp_d = samp_q + CNT_W'(1);
            if (mismatch) begin
                if (err_q == '0) first_d = samp_q;
                if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
            end
            phase_d = phase_end ? RAND_LAST : (phase_q - 16'd1);
            if (state_q == SWEEP) begin
                // Sweep end hands over to the freshly loaded seed, not an advanced value.
                stim_d = phase_end ? abcd_to_dcba(lfsr_q[3:0]) : (stim_q + 4'd1);
            end else begin
                lfsr_adv = 1'b1;
                stim_d   = abcd_to_dcba(lfsr_nxt[3:0]);
            end
        end

        busy_d = (state_d == SWEEP) || (state_d == RANDOM);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    assign a             = stim_q[0];
    assign b             = stim_q[1];
    assign c             = stim_q[2];
    assign d             = stim_q[3];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign sample_count  = samp_q;

endmodule

// File: tb/tb_aoi_sweep_checker.sv
module tb_aoi_sweep_checker;

    localparam int          SWEEP_LEN = 20;
    localparam int          RAND_LEN  = 100;
    localparam int          TOTAL     = SWEEP_LEN + RAND_LEN;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       a, b, c, d, out, out_n, busy, done, pass;
    logic [7:0] err_count, first_err_idx, sample_count;
    logic       a_s, b_s, c_s, d_s, out_s, out_n_s, busy_s, done_s, pass_s;
    logic [3:0] err_s, first_s, samp_s;

    // 0 golden, 1 out stuck 0 / out_n stuck 1, 2 out_n tied to out, 3 out inverted on masked vectors
    int          mode = 0;
    logic [15:0] mask = 16'h0;

    int errors = 0;
    int checks = 0;
    int done_rises = 0;
    int runs_done = 0;

    typedef struct {
        int       err;
        int       first;
        int       err_small;
        int       first_small;
        int       pass;
        logic [3:0] held;
    } res_t;

    res_t       res_q[$];
    logic [3:0] vec_q[$];   // expected {a,b,c,d} per busy cycle

    always #5 clk = ~clk;

    aoi_sweep_checker dut (
        .clk(clk), .reset(reset), .start(start),
        .a(a), .b(b), .c(c), .d(d), .out(out), .out_n(out_n),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .sample_count(sample_count)
    );

    aoi_sweep_checker #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .start(start),
        .a(a_s), .b(b_s), .c(c_s), .d(d_s), .out(out_s), .out_n(out_n_s),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_s), .first_err_idx(first_s), .sample_count(samp_s)
    );

    // Behavioural AOI block with optional fault, returns {out,out_n}
    function automatic logic [1:0] aoi_resp(input int m, input logic [15:0] mk,
                                            input logic ia, input logic ib,
                                            input logic ic, input logic id);
        logic e;
        int   v;
        e = (ia && ib) || (ic && id);
        v = int'(id) * 8 + int'(ic) * 4 + int'(ib) * 2 + int'(ia);
        if (m == 1) return 2'b01;
        if (m == 2) return {e, e};
        if (m == 3 && mk[v]) return {~e, ~e};
        return {e, ~e};
    endfunction

    assign {out, out_n}     = aoi_resp(mode, mask, a, b, c, d);
    assign {out_s, out_n_s} = aoi_resp(mode, mask, a_s, b_s, c_s, d_s);

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference run: vector list and final statistics from the rules alone
    task automatic build_run();
        logic [15:0] l;
        logic [3:0]  dcba, v;
        logic [1:0]  r;
        logic        e;
        int          errs, first;
        res_t        res;
        l = SEED;
        errs = 0;
        first = -1;
        for (int j = 0; j < TOTAL; j++) begin
            if (j < SWEEP_LEN) begin
                dcba = 4'(j % 16);
                v = {dcba[0], dcba[1], dcba[2], dcba[3]};
            end else begin
                if (j > SWEEP_LEN) l = lfsr_adv(l);
                v = l[3:0];
            end
            vec_q.push_back(v);
            e = (v[3] && v[2]) || (v[1] && v[0]);
            r = aoi_resp(mode, mask, v[3], v[2], v[1], v[0]);
            if (r[1] != e || r[0] != !e) begin
                if (first < 0) first = j;
                errs++;
            end
        end
        l = lfsr_adv(l);
        res.held        = l[3:0];
        res.err         = (errs > 255) ? 255 : errs;
        res.err_small   = (errs > 15) ? 15 : errs;
        res.first       = first;
        res.first_small = first % 16;
        res.pass        = (errs == 0) ? 1 : 0;
        res_q.push_back(res);
    endtask

    // Monitor: stimulus per busy cycle, statistics on each done rising edge
    logic done_prev = 1'b0;
    int   busy_cycles = 0;
    always @(negedge clk) begin
        res_t r;
        logic [3:0] v;
        if (busy) begin
            busy_cycles++;
            if (vec_q.size() == 0) begin
                check("vec_underflow", 1, 0);
            end else begin
                v = vec_q.pop_front();
                check("stim_abcd", int'({a, b, c, d}), int'(v));
            end
        end else if (!done) begin
            busy_cycles = 0;
        end
        if (done && !done_prev) begin
            done_rises++;
            if (res_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                r = res_q.pop_front();
                check("busy_cycles", busy_cycles, TOTAL);
                check("err_count", int'(err_count), r.err);
                check("sample_count", int'(sample_count), TOTAL);
                check("pass", int'(pass), r.pass);
                check("held_abcd", int'({a, b, c, d}), int'(r.held));
                check("err_count_sat4", int'(err_s), r.err_small);
                if (r.err != 0) begin
                    check("first_err_idx", int'(first_err_idx), r.first);
                    check("first_err_idx4", int'(first_s), r.first_small);
                end
            end
            busy_cycles = 0;
        end
        done_prev = done;
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_abcd"}, int'({a, b, c, d}), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_samples"}, int'(sample_count), 0);
        check({tag, "_first"}, int'(first_err_idx), 0);
    endtask

    task automatic run(input int m, input logic [15:0] mk, input int abort_at, input bit noisy);
        int cyc;
        @(negedge clk);
        mode = m;
        mask = mk;
        if (abort_at > 0) begin
            build_run();
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (abort_at) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            check_idle("abort");
            vec_q.delete();
            res_q.delete();
            reset = 1'b0;
            @(negedge clk);
        end
        build_run();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_clr_err", int'(err_count), 0);
        check("start_clr_samples", int'(sample_count), 0);
        check("start_done_low", int'(done), 0);
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = (noisy && busy && ($urandom_range(0, 3) == 0)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        if (!done) check("done_timeout", cyc, TOTAL);
        runs_done++;
        repeat (3) @(negedge clk);
        check("hold_samples", int'(sample_count), TOTAL);
        check("hold_done", int'(done), 1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;

        run(0, 16'h0, 0, 1'b0);
        run(1, 16'h0, 0, 1'b1);
        run(2, 16'h0, 0, 1'b0);
        run(3, 16'($urandom), 5, 1'b0);
        run(0, 16'h0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run($urandom_range(0, 3), 16'($urandom), 0, (i % 2) == 1);
        end

        repeat (5) @(negedge clk);
        check("pending_results", res_q.size(), 0);
        check("pending_vectors", vec_q.size(), 0);
        check("done_count", done_rises, runs_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
